// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave
//  Description : SPI target. sclk, mosi and ss are oversampled in the clk
//                domain through 2-flop synchronisers plus a previous-value
//                stage for edge detection. Received bits are deserialised
//                into rx_data and qualified by a one-cycle rx_valid strobe.
//                Transmit words come from a one-deep holding buffer and are
//                serialised onto miso. CPHA/CPOL/bit order match spi_master.
//                2**LEN_WIDTH must exceed DATA_WIDTH.
//  Ports       : clk, rst          - system clock, synchronous active-high reset
//                sclk, mosi, ss    - SPI bus inputs (ss active low)
//                miso              - SPI serial output
//                dir_transfer      - 1 = MSB first, latched at frame start
//                tx_data/tx_valid/tx_ready - holding-buffer write handshake
//                rx_data/rx_len/rx_valid   - received word, bit count, strobe
//                tx_underrun       - word started with an empty buffer
//                busy              - frame in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave #(
    parameter int DATA_WIDTH   = 8,
    parameter int LEN_WIDTH    = 4,
    parameter int PHASE_CLK    = 0,
    parameter int POLARITY_CLK = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  ss,
    output logic                  miso,
    input  logic                  dir_transfer,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic [LEN_WIDTH-1:0]  rx_len,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_LOAD  = 3'd2,
        S_SHIFT = 3'd3,
        S_END   = 3'd4
    } state_t;

    localparam logic [LEN_WIDTH-1:0] c_WORD_LEN  = LEN_WIDTH'(DATA_WIDTH);
    localparam logic                 c_SCLK_IDLE = (POLARITY_CLK != 0);

    // ------------------------------------------------------------------
    // Bit-order helpers
    // ------------------------------------------------------------------
    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] word,
                                       input logic                  msb);
        return msb ? word[DATA_WIDTH-1] : word[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] tx_advance(input logic [DATA_WIDTH-1:0] word,
                                                         input logic                  msb);
        return msb ? {word[DATA_WIDTH-2:0], 1'b0} : {1'b0, word[DATA_WIDTH-1:1]};
    endfunction

    // MSB-first words build up from the LSB side (right-aligned partials),
    // LSB-first words build up from the MSB side (left-aligned partials).
    function automatic logic [DATA_WIDTH-1:0] rx_insert(input logic [DATA_WIDTH-1:0] word,
                                                        input logic                  msb,
                                                        input logic                  din);
        return msb ? {word[DATA_WIDTH-2:0], din} : {din, word[DATA_WIDTH-1:1]};
    endfunction

    // ------------------------------------------------------------------
    // Synchronisers and edge detection
    // ------------------------------------------------------------------
    logic r_sclk_meta_q, r_sclk_sync_q, r_sclk_prev_q;
    logic r_mosi_meta_q, r_mosi_sync_q;
    logic r_ss_meta_q,   r_ss_sync_q,   r_ss_prev_q;

    logic w_sclk_rise, w_sclk_fall, w_lead_edge, w_trail_edge;
    logic w_sample_edge, w_drive_edge, w_ss_fall;

    assign w_sclk_rise   =  r_sclk_sync_q & ~r_sclk_prev_q;
    assign w_sclk_fall   = ~r_sclk_sync_q &  r_sclk_prev_q;
    assign w_lead_edge   = (POLARITY_CLK != 0) ? w_sclk_fall : w_sclk_rise;
    assign w_trail_edge  = (POLARITY_CLK != 0) ? w_sclk_rise : w_sclk_fall;
    assign w_sample_edge = (PHASE_CLK != 0) ? w_trail_edge : w_lead_edge;
    assign w_drive_edge  = (PHASE_CLK != 0) ? w_lead_edge  : w_trail_edge;
    assign w_ss_fall     = ~r_ss_sync_q & r_ss_prev_q;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                  r_state_q,     w_state_d;
    logic [LEN_WIDTH-1:0]    r_cnt_q,       w_cnt_d;
    logic [DATA_WIDTH-1:0]   r_rx_sh_q,     w_rx_sh_d;
    logic [DATA_WIDTH-1:0]   r_tx_sh_q,     w_tx_sh_d;
    logic                    r_msb_first_q, w_msb_first_d;
    logic                    r_miso_q,      w_miso_d;
    logic                    r_busy_q,      w_busy_d;
    logic [DATA_WIDTH-1:0]   r_rx_data_q,   w_rx_data_d;
    logic [LEN_WIDTH-1:0]    r_rx_len_q,    w_rx_len_d;
    logic                    r_rx_valid_q,  w_rx_valid_d;
    logic                    r_udr_q,       w_udr_d;
    logic                    r_udr_pend_q,  w_udr_pend_d;
    logic                    r_loaded_q,    w_loaded_d;
    logic [DATA_WIDTH-1:0]   r_buf_q,       w_buf_d;
    logic                    r_buf_full_q,  w_buf_full_d;

    logic                    w_accept;
    logic                    w_load;
    logic                    w_load_now;
    logic [DATA_WIDTH-1:0]   w_buf_word;
    logic [DATA_WIDTH-1:0]   w_word;
    logic [DATA_WIDTH-1:0]   w_rx_next;
    logic [LEN_WIDTH-1:0]    w_cnt_inc;

    assign w_accept   = tx_valid & ~r_buf_full_q;
    assign w_buf_word = r_buf_full_q ? r_buf_q : '0;
    assign w_rx_next  = rx_insert(r_rx_sh_q, r_msb_first_q, r_mosi_sync_q);
    assign w_cnt_inc  = r_cnt_q + 1'b1;

    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_rx_sh_d     = r_rx_sh_q;
        w_tx_sh_d     = r_tx_sh_q;
        w_msb_first_d = r_msb_first_q;
        w_miso_d      = r_miso_q;
        w_busy_d      = r_busy_q;
        w_rx_data_d   = r_rx_data_q;
        w_rx_len_d    = r_rx_len_q;
        w_rx_valid_d  = 1'b0;
        w_udr_d       = 1'b0;
        w_udr_pend_d  = r_udr_pend_q;
        w_loaded_d    = r_loaded_q;
        w_load        = 1'b0;
        w_load_now    = 1'b0;
        w_word        = r_tx_sh_q;

        case (r_state_q)
            S_IDLE: begin
                w_busy_d = 1'b0;
                w_miso_d = 1'b0;
                if (r_ss_sync_q) begin
                    w_state_d = S_ARMED;
                end
            end

            S_ARMED: begin
                w_busy_d = 1'b0;
                w_miso_d = 1'b0;
                if (w_ss_fall) begin
                    w_msb_first_d = dir_transfer;
                    w_state_d     = S_LOAD;
                end
            end

            S_LOAD: begin
                w_load       = 1'b1;
                w_load_now   = 1'b1;
                w_tx_sh_d    = w_buf_word;
                w_miso_d     = (PHASE_CLK == 0) ? first_bit(w_buf_word, r_msb_first_q) : 1'b0;
                w_cnt_d      = '0;
                w_rx_sh_d    = '0;
                w_busy_d     = 1'b1;
                w_loaded_d   = 1'b1;
                w_udr_pend_d = 1'b0;
                w_state_d    = S_SHIFT;
            end

            S_SHIFT: begin
                if (w_sample_edge) begin
                    // A word pre-loaded empty at the end of the previous word
                    // is only reported once it actually starts clocking.
                    if ((r_cnt_q == '0) && r_udr_pend_q) begin
                        w_udr_d      = 1'b1;
                        w_udr_pend_d = 1'b0;
                    end
                    if (w_cnt_inc == c_WORD_LEN) begin
                        w_rx_valid_d = 1'b1;
                        w_rx_data_d  = w_rx_next;
                        w_rx_len_d   = c_WORD_LEN;
                        w_cnt_d      = '0;
                        w_rx_sh_d    = '0;
                    end else begin
                        w_cnt_d   = w_cnt_inc;
                        w_rx_sh_d = w_rx_next;
                    end
                end
                if (w_drive_edge) begin
                    if (r_cnt_q != '0) begin
                        w_word = tx_advance(r_tx_sh_q, r_msb_first_q);
                    end else if ((PHASE_CLK != 0) && r_loaded_q) begin
                        // First word of the frame was already loaded in S_LOAD.
                        w_word     = r_tx_sh_q;
                        w_loaded_d = 1'b0;
                    end else begin
                        w_load     = 1'b1;
                        w_load_now = (PHASE_CLK != 0);
                        w_word     = w_buf_word;
                    end
                    w_tx_sh_d = w_word;
                    w_miso_d  = first_bit(w_word, r_msb_first_q);
                end
                if (r_ss_sync_q) begin
                    w_state_d = S_END;
                end
            end

            S_END: begin
                if (r_cnt_q != '0) begin
                    w_rx_valid_d = 1'b1;
                    w_rx_data_d  = r_rx_sh_q;
                    w_rx_len_d   = r_cnt_q;
                end
                w_cnt_d      = '0;
                w_busy_d     = 1'b0;
                w_miso_d     = 1'b0;
                w_udr_pend_d = 1'b0;
                w_loaded_d   = 1'b0;
                w_state_d    = S_ARMED;
            end

            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        if (w_load && !r_buf_full_q) begin
            if (w_load_now) begin
                w_udr_d = 1'b1;
            end else begin
                w_udr_pend_d = 1'b1;
            end
        end

        w_buf_full_d = (r_buf_full_q & ~w_load) | w_accept;
        w_buf_d      = w_accept ? tx_data : r_buf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_meta_q <= c_SCLK_IDLE;
            r_sclk_sync_q <= c_SCLK_IDLE;
            r_sclk_prev_q <= c_SCLK_IDLE;
            r_mosi_meta_q <= 1'b0;
            r_mosi_sync_q <= 1'b0;
            // ss pipeline resets low so a frame already in flight is not
            // mistaken for a fresh falling edge.
            r_ss_meta_q   <= 1'b0;
            r_ss_sync_q   <= 1'b0;
            r_ss_prev_q   <= 1'b0;
            r_state_q     <= S_IDLE;
            r_cnt_q       <= '0;
            r_rx_sh_q     <= '0;
            r_tx_sh_q     <= '0;
            r_msb_first_q <= 1'b1;
            r_miso_q      <= 1'b0;
            r_busy_q      <= 1'b0;
            r_rx_data_q   <= '0;
            r_rx_len_q    <= '0;
            r_rx_valid_q  <= 1'b0;
            r_udr_q       <= 1'b0;
            r_udr_pend_q  <= 1'b0;
            r_loaded_q    <= 1'b0;
            r_buf_q       <= '0;
            r_buf_full_q  <= 1'b0;
        end else begin
            r_sclk_meta_q <= sclk;
            r_sclk_sync_q <= r_sclk_meta_q;
            r_sclk_prev_q <= r_sclk_sync_q;
            r_mosi_meta_q <= mosi;
            r_mosi_sync_q <= r_mosi_meta_q;
            r_ss_meta_q   <= ss;
            r_ss_sync_q   <= r_ss_meta_q;
            r_ss_prev_q   <= r_ss_sync_q;
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_rx_sh_q     <= w_rx_sh_d;
            r_tx_sh_q     <= w_tx_sh_d;
            r_msb_first_q <= w_msb_first_d;
            r_miso_q      <= w_miso_d;
            r_busy_q      <= w_busy_d;
            r_rx_data_q   <= w_rx_data_d;
            r_rx_len_q    <= w_rx_len_d;
            r_rx_valid_q  <= w_rx_valid_d;
            r_udr_q       <= w_udr_d;
            r_udr_pend_q  <= w_udr_pend_d;
            r_loaded_q    <= w_loaded_d;
            r_buf_q       <= w_buf_d;
            r_buf_full_q  <= w_buf_full_d;
        end
    end

    assign miso        = r_miso_q;
    assign tx_ready    = ~r_buf_full_q;
    assign rx_data     = r_rx_data_q;
    assign rx_len      = r_rx_len_q;
    assign rx_valid    = r_rx_valid_q;
    assign tx_underrun = r_udr_q;
    assign busy        = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave
//  Description : Self-checking bench for spi_slave. Instance 0 runs mode 0
//                (CPHA=0, CPOL=0), instance 1 runs mode 3 (CPHA=1, CPOL=1).
//                The bench plays SPI master, pushes expected rx words into a
//                scoreboard and a monitor pops them on every rx_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

    localparam int c_HP = 8;   // sclk half period in clk cycles

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       sclk_a      [2];
    logic       mosi_a      [2];
    logic       ss_a        [2];
    logic       dir_a       [2];
    logic       tx_valid_a  [2];
    logic [7:0] tx_data_a   [2];
    logic       miso_a      [2];
    logic       tx_ready_a  [2];
    logic [7:0] rx_data_a   [2];
    logic [3:0] rx_len_a    [2];
    logic       rx_valid_a  [2];
    logic       udr_a       [2];
    logic       busy_a      [2];

    spi_slave #(.DATA_WIDTH(8), .LEN_WIDTH(4), .PHASE_CLK(0), .POLARITY_CLK(0)) u_dut0 (
        .clk(clk), .rst(rst), .sclk(sclk_a[0]), .mosi(mosi_a[0]), .ss(ss_a[0]),
        .miso(miso_a[0]), .dir_transfer(dir_a[0]), .tx_data(tx_data_a[0]),
        .tx_valid(tx_valid_a[0]), .tx_ready(tx_ready_a[0]), .rx_data(rx_data_a[0]),
        .rx_len(rx_len_a[0]), .rx_valid(rx_valid_a[0]), .tx_underrun(udr_a[0]),
        .busy(busy_a[0])
    );

    spi_slave #(.DATA_WIDTH(8), .LEN_WIDTH(4), .PHASE_CLK(1), .POLARITY_CLK(1)) u_dut1 (
        .clk(clk), .rst(rst), .sclk(sclk_a[1]), .mosi(mosi_a[1]), .ss(ss_a[1]),
        .miso(miso_a[1]), .dir_transfer(dir_a[1]), .tx_data(tx_data_a[1]),
        .tx_valid(tx_valid_a[1]), .tx_ready(tx_ready_a[1]), .rx_data(rx_data_a[1]),
        .rx_len(rx_len_a[1]), .rx_valid(rx_valid_a[1]), .tx_underrun(udr_a[1]),
        .busy(busy_a[1])
    );

    int         total;
    int         bad;
    int         udr_cnt [2];
    logic [7:0] exp_d   [2][$];
    int         exp_l   [2][$];
    logic [7:0] txq     [2][$];
    logic [7:0] mo_w    [2];
    logic [7:0] tx_w    [2];

    task automatic check(input string name, input int inst, input logic [31:0] act,
                         input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s inst%0d: got %0h expected %0h", name, inst, act, expv);
        end
    endtask

    task automatic check_reset_vals(input int i);
        check("rst_miso",     i, 32'(miso_a[i]),     32'd0);
        check("rst_tx_ready", i, 32'(tx_ready_a[i]), 32'd1);
        check("rst_busy",     i, 32'(busy_a[i]),     32'd0);
        check("rst_rx_valid", i, 32'(rx_valid_a[i]), 32'd0);
        check("rst_rx_data",  i, 32'(rx_data_a[i]),  32'd0);
        check("rst_rx_len",   i, 32'(rx_len_a[i]),   32'd0);
        check("rst_underrun", i, 32'(udr_a[i]),      32'd0);
    endtask

    // One ss frame of nbits bits from mo_w[], slave preloaded with ntx words
    // from tx_w[]. rst_at >= 0 pulses rst before that bit with ss held low.
    task automatic xfer(input int inst, input bit msb, input int nbits,
                        input int ntx, input int rst_at);
        int         nwords;
        int         u0;
        int         n;
        int         w;
        int         pos;
        int         tmo;
        logic       cpol;
        logic       cpha;
        logic [7:0] cap [2];
        logic [7:0] e;
        logic [7:0] mask;
        nwords = (nbits + 7) / 8;
        cpol   = (inst == 1);
        cpha   = (inst == 1);
        cap[0] = 8'h00;
        cap[1] = 8'h00;

        for (int k = 0; k < ntx; k++) txq[inst].push_back(tx_w[k]);
        if (ntx > 0) begin
            tmo = 0;
            while (tx_ready_a[inst] && tmo < 20) begin
                @(negedge clk);
                tmo++;
            end
            if (tmo >= 20) check("preload_timeout", inst, 32'd1, 32'd0);
        end

        if (rst_at < 0) begin
            for (int k = 0; k < nwords; k++) begin
                n = (nbits - 8 * k > 8) ? 8 : nbits - 8 * k;
                if (n == 8)   e = mo_w[k];
                else if (msb) e = mo_w[k] >> (8 - n);
                else          e = mo_w[k] << (8 - n);
                exp_d[inst].push_back(e);
                exp_l[inst].push_back(n);
            end
        end

        u0          = udr_cnt[inst];
        dir_a[inst] = msb;
        ss_a[inst]  = 1'b0;
        mosi_a[inst] = mo_w[0][msb ? 7 : 0];
        repeat (c_HP + 2) @(negedge clk);

        for (int b = 0; b < nbits; b++) begin
            w   = b / 8;
            pos = msb ? 7 - (b % 8) : (b % 8);
            if (b == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_reset_vals(inst);
            end
            if (!cpha) begin
                cap[w][pos]  = miso_a[inst];
                sclk_a[inst] = ~cpol;
                repeat (c_HP) @(negedge clk);
                sclk_a[inst] = cpol;
                if (b + 1 < nbits)
                    mosi_a[inst] = mo_w[(b + 1) / 8][msb ? 7 - ((b + 1) % 8) : ((b + 1) % 8)];
                repeat (c_HP) @(negedge clk);
            end else begin
                sclk_a[inst] = ~cpol;
                mosi_a[inst] = mo_w[w][pos];
                repeat (c_HP) @(negedge clk);
                cap[w][pos]  = miso_a[inst];
                sclk_a[inst] = cpol;
                repeat (c_HP) @(negedge clk);
            end
            if (b == 0 && rst_at < 0) check("busy_in_frame", inst, 32'(busy_a[inst]), 32'd1);
        end

        repeat (c_HP) @(negedge clk);
        ss_a[inst] = 1'b1;
        repeat (3 * c_HP) @(negedge clk);

        if (rst_at < 0) begin
            for (int k = 0; k < nwords; k++) begin
                n    = (nbits - 8 * k > 8) ? 8 : nbits - 8 * k;
                mask = msb ? (8'hFF << (8 - n)) : (8'hFF >> (8 - n));
                e    = (k < ntx) ? tx_w[k] : 8'h00;
                check("miso_word", inst, 32'(cap[k] & mask), 32'(e & mask));
            end
            check("underrun_count", inst, 32'(udr_cnt[inst] - u0), 32'(nwords - ntx));
        end else begin
            check("underrun_count", inst, 32'(udr_cnt[inst] - u0), 32'd0);
        end
        check("rx_pending", inst, 32'(exp_d[inst].size()), 32'd0);
        check("busy_after", inst, 32'(busy_a[inst]), 32'd0);
        check("tx_ready_after", inst, 32'(tx_ready_a[inst]), 32'd1);
    endtask

    initial begin
        logic [7:0] ed;
        int         el;
        int         ninst;
        int         nb;
        int         nw;
        bit         m;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sclk_a[i]     = (i == 1);
            mosi_a[i]     = 1'b0;
            ss_a[i]       = 1'b1;
            dir_a[i]      = 1'b1;
            tx_valid_a[i] = 1'b0;
            tx_data_a[i]  = 8'h00;
            udr_cnt[i]    = 0;
        end

        fork
            // Scoreboard monitor
            forever begin
                @(negedge clk);
                for (int i = 0; i < 2; i++) begin
                    if (udr_a[i]) udr_cnt[i]++;
                    if (rx_valid_a[i]) begin
                        if (exp_d[i].size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL rx_unexpected inst%0d: got data %0h len %0d, expected no strobe",
                                     i, rx_data_a[i], rx_len_a[i]);
                        end else begin
                            ed = exp_d[i].pop_front();
                            el = exp_l[i].pop_front();
                            check("rx_data", i, 32'(rx_data_a[i]), 32'(ed));
                            check("rx_len",  i, 32'(rx_len_a[i]),  32'(el));
                        end
                    end
                end
            end
            // Holding-buffer feeder
            forever begin
                @(negedge clk);
                for (int i = 0; i < 2; i++) begin
                    if (tx_valid_a[i]) begin
                        tx_valid_a[i] = 1'b0;
                    end else if (tx_ready_a[i] && txq[i].size() > 0) begin
                        tx_data_a[i]  = txq[i].pop_front();
                        tx_valid_a[i] = 1'b1;
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check_reset_vals(0);
        check_reset_vals(1);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Mode 0, MSB first, 0x17 in, 0xA5 out
        mo_w[0] = 8'h17; tx_w[0] = 8'hA5;
        xfer(0, 1'b1, 8, 1, -1);
        // Two words in one frame
        mo_w[0] = 8'h16; mo_w[1] = 8'h15; tx_w[0] = 8'h3C; tx_w[1] = 8'hC3;
        xfer(0, 1'b1, 16, 2, -1);
        // No tx word: underrun, miso zero
        mo_w[0] = 8'h14;
        xfer(0, 1'b1, 8, 0, -1);
        // Partial frame: 1,0,1,1,0 -> 0x16 len 5
        mo_w[0] = 8'hB0; tx_w[0] = 8'h5A;
        xfer(0, 1'b1, 5, 1, -1);
        // Mode 3, LSB first
        mo_w[0] = 8'h12; tx_w[0] = 8'h9E;
        xfer(1, 1'b0, 8, 1, -1);
        // Reset mid-frame, then a normal frame
        mo_w[0] = 8'hC7; tx_w[0] = 8'h33;
        xfer(0, 1'b1, 8, 1, 3);
        mo_w[0] = 8'h6D; tx_w[0] = 8'h81;
        xfer(0, 1'b1, 8, 1, -1);

        // Randomised frames on both instances
        for (int t = 0; t < 24; t++) begin
            ninst   = $urandom_range(0, 1);
            m       = 1'($urandom_range(0, 1));
            nb      = $urandom_range(1, 16);
            nw      = (nb + 7) / 8;
            mo_w[0] = 8'($urandom);
            mo_w[1] = 8'($urandom);
            tx_w[0] = 8'($urandom);
            tx_w[1] = 8'($urandom);
            xfer(ninst, m, nb, $urandom_range(0, nw), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
